// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared load-unit definitions: funct3 load encodings, FSM states, default timeout
// and the misalignment predicate used by the optional YSYX_23060201_LSU_MISALIGN_CHK_EN check.
package ysyx_23060201_lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam int DEFAULT_TIMEOUT_CYC = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } lsu_state_t;

   // Encodings other than the byte/half loads behave as LW, so they get the word check.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      case (funct3)
         F3_LB, F3_LBU: mis = 1'b0;
         F3_LH, F3_LHU: mis = addr_lo[0];
         default:       mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/ysyx_23060201_load_ext.sv
// Combinational lane selection and sign/zero extension of a loaded memory word.
module ysyx_23060201_load_ext
   import ysyx_23060201_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'b00:   byte_sel = rdata[7:0];
         2'b01:   byte_sel = rdata[15:8];
         2'b10:   byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {24'd0, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/ysyx_23060201_lsu_read.sv
// Load/store unit read path: one load at a time, bounded memory wait, registered result.
// Define YSYX_23060201_LSU_MISALIGN_CHK_EN to reject misaligned LH/LHU/LW without a memory access.
module ysyx_23060201_lsu_read
   import ysyx_23060201_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [2:0]            req_funct3,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic                  rsp_err
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   lsu_state_t       state;
   lsu_state_t       state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic [2:0]       funct3_q;
   logic [1:0]       addr_lo_q;
   logic [31:0]      ext_data;
   logic             accept;
   logic             misaligned;
   logic             timeout;

`ifdef YSYX_23060201_LSU_MISALIGN_CHK_EN
   assign misaligned = is_misaligned(req_funct3, req_addr[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   assign accept  = req_valid && (state == ST_IDLE);
   assign timeout = (wait_cnt == CNT_MAX);

   ysyx_23060201_load_ext u_load_ext (
      .funct3  (funct3_q),
      .addr_lo (addr_lo_q),
      .rdata   (mem_rdata[31:0]),
      .data    (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_valid) state_nxt = misaligned ? ST_RESP : ST_REQ;
         ST_REQ:  state_nxt = ST_WAIT;
         ST_WAIT: if (mem_rvalid || timeout) state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == ST_IDLE);
      mem_ren   = (state == ST_REQ);
      rsp_valid = (state == ST_RESP);
   end

   // Data wins over a coinciding timeout because the rvalid test comes first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         funct3_q  <= '0;
         addr_lo_q <= '0;
         mem_raddr <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  funct3_q  <= req_funct3;
                  addr_lo_q <= req_addr[1:0];
                  wait_cnt  <= '0;
                  if (misaligned) begin
                     rsp_data <= '0;
                     rsp_err  <= 1'b1;
                  end else begin
                     mem_raddr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  end
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  rsp_data <= ext_data;
                  rsp_err  <= 1'b0;
               end else if (timeout) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060201_lsu_read.sv
// Directed self-checking bench for ysyx_23060201_lsu_read with hand-computed expectations.
module tb_ysyx_23060201_lsu_read;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic        mem_ren;
   logic [31:0] mem_raddr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;

   ysyx_23060201_lsu_read dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .mem_ren    (mem_ren),
      .mem_raddr  (mem_raddr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single edge; returns one cycle after acceptance.
   task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] f3);
      req_addr   = addr;
      req_funct3 = f3;
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
   endtask

   task automatic runLoad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [31:0] exp_raddr,
                          input logic [31:0] exp_data);
      applyStimulus(addr, f3);
      checkOutput({tag, ".ren"}, {31'd0, mem_ren}, 32'd1);
      checkOutput({tag, ".raddr"}, mem_raddr, exp_raddr);
      checkOutput({tag, ".ready_busy"}, {31'd0, req_ready}, 32'd0);
      tick();
      checkOutput({tag, ".ren_off"}, {31'd0, mem_ren}, 32'd0);
      checkOutput({tag, ".valid_wait"}, {31'd0, rsp_valid}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      checkOutput({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
      checkOutput({tag, ".data"}, rsp_data, exp_data);
      checkOutput({tag, ".err"}, {31'd0, rsp_err}, 32'd0);
      checkOutput({tag, ".raddr_hold"}, mem_raddr, exp_raddr);
   endtask

   task automatic finishResp(input string tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput({tag, ".valid_done"}, {31'd0, rsp_valid}, 32'd0);
      checkOutput({tag, ".ready_idle"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = 32'h0;
      req_funct3 = 3'b000;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      rsp_ready  = 1'b0;

      #2;
      checkOutput("rst.ren", {31'd0, mem_ren}, 32'd0);
      checkOutput("rst.raddr", mem_raddr, 32'h0);
      checkOutput("rst.valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("rst.data", rsp_data, 32'h0);
      checkOutput("rst.err", {31'd0, rsp_err}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("rst.ready", {31'd0, req_ready}, 32'd1);

      runLoad("lw", 32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 32'h8000_0004, 32'hDEAD_BEEF);
      finishResp("lw");
      runLoad("lb", 32'h8000_0003, 3'b000, 32'h80FF_1234, 32'h8000_0000, 32'hFFFF_FF80);
      finishResp("lb");
      runLoad("lbu", 32'h8000_0003, 3'b100, 32'h80FF_1234, 32'h8000_0000, 32'h0000_0080);
      finishResp("lbu");
      runLoad("lb1", 32'h8000_0001, 3'b000, 32'h80FF_1234, 32'h8000_0000, 32'h0000_0012);
      finishResp("lb1");
      runLoad("lh", 32'h8000_0002, 3'b001, 32'h8001_ABCD, 32'h8000_0000, 32'hFFFF_8001);
      finishResp("lh");
      runLoad("lhu", 32'h8000_0002, 3'b101, 32'h8001_ABCD, 32'h8000_0000, 32'h0000_8001);
      finishResp("lhu");
      runLoad("lh0", 32'h8000_0000, 3'b001, 32'h8001_ABCD, 32'h8000_0000, 32'hFFFF_ABCD);
      finishResp("lh0");
      runLoad("f3_011", 32'h8000_0008, 3'b011, 32'h8765_4321, 32'h8000_0008, 32'h8765_4321);
      finishResp("f3_011");

      // Timeout after 16 WAIT cycles, then late data must not disturb the result.
      applyStimulus(32'h8000_0010, 3'b010);
      tick();
      repeat (15) tick();
      checkOutput("to.valid_pre", {31'd0, rsp_valid}, 32'd0);
      tick();
      checkOutput("to.valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("to.err", {31'd0, rsp_err}, 32'd1);
      checkOutput("to.data", rsp_data, 32'h0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      tick();
      checkOutput("to.late_data", rsp_data, 32'h0);
      checkOutput("to.late_err", {31'd0, rsp_err}, 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tick();
      checkOutput("to.idle_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("to.idle_ready", {31'd0, req_ready}, 32'd1);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;

      // Data arriving on the final WAIT cycle beats the timeout.
      applyStimulus(32'h8000_0020, 3'b010);
      tick();
      repeat (15) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0BAD_C0DE;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      checkOutput("race.valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("race.err", {31'd0, rsp_err}, 32'd0);
      checkOutput("race.data", rsp_data, 32'h0BAD_C0DE);
      finishResp("race");

      runLoad("bp", 32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 32'h8000_0004, 32'hDEAD_BEEF);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp.valid", {31'd0, rsp_valid}, 32'd1);
         checkOutput("bp.data", rsp_data, 32'hDEAD_BEEF);
         checkOutput("bp.err", {31'd0, rsp_err}, 32'd0);
         checkOutput("bp.ready", {31'd0, req_ready}, 32'd0);
      end
      finishResp("bp");

      // Asynchronous reset in the middle of WAIT.
      applyStimulus(32'h8000_0003, 3'b100);
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("mrst.ren", {31'd0, mem_ren}, 32'd0);
      checkOutput("mrst.raddr", mem_raddr, 32'h0);
      checkOutput("mrst.valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("mrst.data", rsp_data, 32'h0);
      checkOutput("mrst.err", {31'd0, rsp_err}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111_1111;
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("mrst.after_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("mrst.after_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("mrst.after_data", rsp_data, 32'h0);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;

`ifdef YSYX_23060201_LSU_MISALIGN_CHK_EN
      applyStimulus(32'h8000_0001, 3'b010);
      checkOutput("mis.ren", {31'd0, mem_ren}, 32'd0);
      checkOutput("mis.valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("mis.err", {31'd0, rsp_err}, 32'd1);
      checkOutput("mis.data", rsp_data, 32'h0);
      tick();
      checkOutput("mis.ren_later", {31'd0, mem_ren}, 32'd0);
      finishResp("mis");
`else
      runLoad("mis", 32'h8000_0001, 3'b010, 32'h1357_9BDF, 32'h8000_0000, 32'h1357_9BDF);
      finishResp("mis");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_23060201_lsu_read.md
YSYX_23060201_LSU_READ -- requirements
Module: ysyx_23060201_lsu_read

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the memory word width; only 32 is supported.
REQ-003 Parameter TIMEOUT_CYC, default 16, SHALL set the maximum number of WAIT cycles before a load is aborted.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port req_valid, input, 1 bit: a load request is present.
REQ-007 Port req_ready, output, 1 bit: the block accepts a request.
REQ-008 Port req_addr, input, ADDR_WIDTH bits: the load byte address.
REQ-009 Port req_funct3, input, 3 bits: the load type (LB=000, LH=001, LW=010, LBU=100, LHU=101).
REQ-010 Port mem_ren, output, 1 bit: one-cycle memory read strobe.
REQ-011 Port mem_raddr, output, ADDR_WIDTH bits: word-aligned read address.
REQ-012 Port mem_rvalid, input, 1 bit: memory read data is valid.
REQ-013 Port mem_rdata, input, DATA_WIDTH bits: memory read word.
REQ-014 Port rsp_valid, output, 1 bit: load result is valid.
REQ-015 Port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-016 Port rsp_data, output, 32 bits: the extended load result.
REQ-017 Port rsp_err, output, 1 bit: the load was aborted (timeout or misalignment).

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready the block SHALL latch addr/funct3 and go to REQ.
REQ-020 In REQ the block SHALL assert mem_ren for exactly one cycle with mem_raddr = latched addr with bits [1:0] cleared, then go to WAIT.
REQ-021 In WAIT, mem_rvalid=1 SHALL capture mem_rdata and move to RESP with rsp_err=0.
REQ-022 The WAIT counter SHALL start at 0 on WAIT entry; if it reaches TIMEOUT_CYC-1 with no mem_rvalid, the block SHALL go to RESP with rsp_data=0 and rsp_err=1.
REQ-023 If mem_rvalid and timeout occur in the same cycle, the data SHALL win (rsp_err=0).
REQ-024 mem_rvalid in IDLE, REQ or RESP SHALL be ignored, including late data after a timeout.
REQ-025 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL be stable until rsp_valid&&rsp_ready, which returns the FSM to IDLE.
REQ-026 Minimum latency SHALL be: accept at cycle N, mem_ren at N+1, rvalid at N+2 at the earliest, rsp_valid at N+3.
REQ-027 Byte lane SHALL be addr[1:0] (LB/LBU) and halfword lane SHALL be addr[1] (LH/LHU); LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend.
REQ-028 An unsupported funct3 (011, 110, 111) SHALL be treated as LW.
REQ-029 Outside REQ, mem_ren SHALL be 0 and mem_raddr SHALL hold its last value.

Reset
REQ-030 Asserting rst_n=0 SHALL, at any time including mid-load, force IDLE, counter=0, mem_ren=0, mem_raddr=0, rsp_valid=0, rsp_data=0, rsp_err=0, and req_ready=1 once released.

Configuration
REQ-031 With YSYX_23060201_LSU_MISALIGN_CHK_EN defined, an LH/LHU with addr[0]=1 or an LW with addr[1:0]!=0 SHALL skip REQ/WAIT and go directly to RESP with rsp_err=1 and rsp_data=0, and no mem_ren.
REQ-032 Without YSYX_23060201_LSU_MISALIGN_CHK_EN, misaligned low address bits SHALL be ignored beyond the lane selection of REQ-027, and a normal access SHALL occur.

Structure
REQ-033 Package ysyx_23060201_lsu_pkg SHALL hold the funct3 load encodings, the FSM state enum and the default TIMEOUT_CYC.
REQ-034 Lane extraction and extension SHALL live in the combinational sub-module ysyx_23060201_load_ext, instantiated once.

Verification
REQ-035 LW, addr 0x80000004, mem_rdata 0xDEADBEEF after 1 cycle -> mem_raddr=0x80000004, rsp_data=0xDEADBEEF, rsp_err=0, rsp_valid at accept+3.
REQ-036 LB, addr 0x80000003, rdata 0x80FF1234 -> rsp_data=0xFFFFFF80; LBU, same inputs -> rsp_data=0x00000080.
REQ-037 LH, addr 0x80000002, rdata 0x8001ABCD -> rsp_data=0xFFFF8001; no mem_rvalid for 16 cycles -> rsp_err=1, rsp_data=0; a late rvalid is ignored.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data and rsp_err stable, req_ready=0; rsp_ready=1 -> IDLE on the next cycle.
REQ-039 rst_n pulsed low in WAIT -> all outputs 0 immediately; a subsequent rvalid is ignored.
REQ-040 With the macro defined: LW at 0x80000001 -> no mem_ren, rsp_err=1 at accept+1; without the macro: mem_raddr=0x80000000.
